// File: rtl/lcd_pkg.sv
// Shared types and 50 MHz timing defaults for the HD44780 read engine.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } lcd_state_e;

    localparam logic LCD_RS_CMD  = 1'b0;
    localparam logic LCD_RS_DATA = 1'b1;

    localparam int unsigned T_AS_DEF     = 3;
    localparam int unsigned T_PW_DEF     = 15;
    localparam int unsigned T_H_DEF      = 2;
    localparam int unsigned T_REC_DEF    = 12;
    localparam int unsigned MAX_POLL_DEF = 255;

    localparam int BF_BIT = 7;

endpackage

// File: rtl/lcd_bus_reader_if.sv
// Request/response and LCD pin bundle for lcd_bus_reader.
interface lcd_bus_reader_if;
    import lcd_pkg::*;

    // Handshake: a request transfers on a clk edge where req_valid & req_ready;
    // req_valid must be held until then. resp_valid is a one-cycle pulse with
    // no backpressure; resp_data/resp_timeout are valid while it is high.
    logic       req_valid;
    logic       req_rs;
    logic       req_ready;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       resp_timeout;
    logic       bus_busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data_in;
    logic       lcd_data_oe;
    lcd_state_e state;

    modport slave (
        input  req_valid, req_rs, lcd_data_in,
        output req_ready, resp_valid, resp_data, resp_timeout, bus_busy,
               lcd_rs, lcd_rw, lcd_en, lcd_data_oe, state
    );

    modport master (
        output req_valid, req_rs, lcd_data_in,
        input  req_ready, resp_valid, resp_data, resp_timeout, bus_busy,
               lcd_rs, lcd_rw, lcd_en, lcd_data_oe, state
    );

endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable 8-bit down-counter timing each bus phase; done when it reaches zero.
module lcd_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= value;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == 8'd0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Timed RW=1 read cycles on the 1602 LCD bus; returns status or data byte.
// Busy-flag polling of status reads is enabled with `define LCD_BF_POLL_EN.
module lcd_bus_reader
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS     = T_AS_DEF,
    parameter int unsigned T_PW     = T_PW_DEF,
    parameter int unsigned T_H      = T_H_DEF,
    parameter int unsigned T_REC    = T_REC_DEF,
    parameter int unsigned MAX_POLL = MAX_POLL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    lcd_bus_reader_if.slave   bus
);

`ifdef LCD_BF_POLL_EN
    localparam bit POLL_EN = 1'b1;
`else
    localparam bit POLL_EN = 1'b0;
`endif

    // Timer counts down to zero inclusive, so each phase loads length-1.
    localparam logic [7:0] AS_LD    = 8'(T_AS - 1);
    localparam logic [7:0] PW_LD    = 8'(T_PW - 1);
    localparam logic [7:0] H_LD     = 8'(T_H - 1);
    localparam logic [7:0] REC_LD   = (T_REC == 0) ? 8'd0 : 8'(T_REC - 1);
    localparam bit         REC_ZERO = (T_REC == 0);
    localparam logic [8:0] MAX_POLL_W = 9'(MAX_POLL);

    lcd_state_e state, state_n;
    logic       load;
    logic [7:0] load_val;
    logic       done;
    logic       accept;
    logic       again;
    logic       again_q;
    logic       rs_q;
    logic [7:0] capture;
    logic [7:0] poll_cnt;
    logic       en_q, rw_q, busy_q;
    logic       resp_valid_q, resp_timeout_q;
    logic [7:0] resp_data_q;

    lcd_phase_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (load_val),
        .done  (done)
    );

    assign bus.req_ready = (state == IDLE) & ~rst;
    assign accept        = bus.req_valid & bus.req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        load_val = 8'd0;
        // Another status read is needed while the busy flag is set and reads remain.
        again    = POLL_EN && (rs_q == LCD_RS_CMD) && capture[BF_BIT] &&
                   (({1'b0, poll_cnt} + 9'd1) < MAX_POLL_W);
        case (state)
            IDLE: if (accept) begin
                state_n = SETUP; load = 1'b1; load_val = AS_LD;
            end
            SETUP: if (done) begin
                state_n = STROBE; load = 1'b1; load_val = PW_LD;
            end
            STROBE: if (done) begin
                state_n = HOLD; load = 1'b1; load_val = H_LD;
            end
            HOLD: if (done) begin
                if (!REC_ZERO) begin
                    state_n = RECOVER; load = 1'b1; load_val = REC_LD;
                end else if (again) begin
                    state_n = SETUP; load = 1'b1; load_val = AS_LD;
                end else begin
                    state_n = IDLE;
                end
            end
            RECOVER: if (done) begin
                if (again_q) begin
                    state_n = SETUP; load = 1'b1; load_val = AS_LD;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pin strobes are registered from the next state so they change cleanly on edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q           <= 1'b0;
            capture        <= 8'd0;
            poll_cnt       <= 8'd0;
            again_q        <= 1'b0;
            en_q           <= 1'b0;
            rw_q           <= 1'b0;
            busy_q         <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= 8'd0;
            resp_timeout_q <= 1'b0;
        end else begin
            en_q         <= (state_n == STROBE);
            rw_q         <= (state_n == SETUP) || (state_n == STROBE) || (state_n == HOLD);
            busy_q       <= (state_n != IDLE);
            resp_valid_q <= 1'b0;
            if (accept) begin
                rs_q     <= bus.req_rs;
                poll_cnt <= 8'd0;
                again_q  <= 1'b0;
            end
            if ((state == STROBE) && done) begin
                capture <= bus.lcd_data_in;
            end
            if ((state == HOLD) && done) begin
                rs_q     <= 1'b0;
                poll_cnt <= poll_cnt + 8'd1;
                again_q  <= again;
                if (!again) begin
                    resp_valid_q   <= 1'b1;
                    resp_data_q    <= capture;
                    resp_timeout_q <= POLL_EN && (rs_q == LCD_RS_CMD) && capture[BF_BIT];
                end
            end
        end
    end

    assign bus.lcd_rs       = rs_q;
    assign bus.lcd_rw       = rw_q;
    assign bus.lcd_en       = en_q;
    assign bus.bus_busy     = busy_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_data    = resp_data_q;
    assign bus.resp_timeout = resp_timeout_q;
    assign bus.lcd_data_oe  = 1'b0;
    assign bus.state        = state;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader: vector table of single reads plus reset/hold/poll sequences.
module tb_lcd_bus_reader;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [7:0] exp_q[$];

    lcd_bus_reader_if bus ();

    lcd_bus_reader #(.MAX_POLL(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] din;
        logic [7:0] exp_data;
        logic       exp_to;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Presents a request and returns after the edge that accepted it.
    task automatic accept_req(input logic rs, input logic [7:0] din);
        logic acc;
        acc = 1'b0;
        bus.lcd_data_in = din;
        bus.req_rs      = rs;
        bus.req_valid   = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = bus.req_ready;
            step();
        end
        bus.req_valid = 1'b0;
        chk("accept", acc, 1);
    endtask

    task automatic do_read(input logic rs, input logic [7:0] din, input int sw,
                           input logic [7:0] din2, input int reads,
                           input logic [7:0] exp_data, input logic exp_to);
        int en_first, en_last, en_cnt, resp_cnt, resp_cyc, ready_cyc, rs_bad, busy_bad;
        logic [7:0] e;
        en_first = -1; en_last = -1; en_cnt = 0; resp_cnt = 0; resp_cyc = -1;
        ready_cyc = -1; rs_bad = 0; busy_bad = 0;
        accept_req(rs, din);
        exp_q.push_back(exp_data);
        chk("rs_at_accept", bus.lcd_rs, rs);
        chk("rw_at_accept", bus.lcd_rw, 1);
        chk("busy_at_accept", bus.bus_busy, 1);
        chk("en_at_accept", bus.lcd_en, 0);
        for (int n = 1; n <= 400 && ready_cyc < 0; n++) begin
            if (n == sw) bus.lcd_data_in = din2;
            step();
            if (bus.lcd_en) begin
                if (en_first < 0) en_first = n;
                en_last = n;
                en_cnt++;
                if (!bus.lcd_rw) rs_bad++;
            end
            if (bus.lcd_rw && (bus.lcd_rs !== rs)) rs_bad++;
            if (bus.resp_valid) begin
                resp_cnt++;
                resp_cyc = n;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("resp_data", bus.resp_data, e);
                end
                chk("resp_timeout", bus.resp_timeout, exp_to);
            end
            if (bus.req_ready) ready_cyc = n;
            else if (!bus.bus_busy) busy_bad++;
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("en_first", en_first, 3);
        chk("en_last", en_last, (reads - 1) * 32 + 17);
        chk("en_cycles", en_cnt, 15 * reads);
        chk("resp_count", resp_cnt, 1);
        chk("resp_cycle", resp_cyc, (reads - 1) * 32 + 20);
        chk("ready_cycle", ready_cyc, reads * 32);
        chk("rs_or_en_glitch", rs_bad, 0);
        chk("busy_drop", busy_bad, 0);
        chk("idle_busy", bus.bus_busy, 0);
        chk("idle_rw", bus.lcd_rw, 0);
        chk("data_oe", bus.lcd_data_oe, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, acc_cnt, acc2, resp_after;
        tests = 0; fails = 0;
        vecs[0] = '{1'b0, 8'h25, 8'h25, 1'b0};
        vecs[1] = '{1'b1, 8'h41, 8'h41, 1'b0};
        vecs[2] = '{1'b1, 8'hff, 8'hff, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h80, 1'b0};
        vecs[5] = '{1'b0, 8'h7f, 8'h7f, 1'b0};

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_rs = 1'b0; bus.lcd_data_in = 8'h00;
        step(); step(); step();
        chk("ready_in_reset", bus.req_ready, 0);
        rst = 1'b0;
        step();
        chk("reset_ready", bus.req_ready, 1);
        chk("reset_en", bus.lcd_en, 0);
        chk("reset_rw", bus.lcd_rw, 0);
        chk("reset_busy", bus.bus_busy, 0);
        chk("reset_resp_valid", bus.resp_valid, 0);
        chk("reset_resp_data", bus.resp_data, 0);
        chk("reset_timeout", bus.resp_timeout, 0);

        foreach (vecs[i]) begin
            do_read(vecs[i].rs, vecs[i].din, 0, 8'h00, 1, vecs[i].exp_data, vecs[i].exp_to);
        end
        step(); step(); step();
        chk("resp_data_hold", bus.resp_data, 8'h7f);

        // req_valid held across an in-flight read
        bus.lcd_data_in = 8'h3c; bus.req_rs = 1'b1; bus.req_valid = 1'b1;
        pulses = 0; acc_cnt = 0; acc2 = -1;
        for (int n = 0; n < 64; n++) begin
            if (bus.req_ready) begin
                acc_cnt++;
                if (acc_cnt == 2) acc2 = n;
            end
            step();
            if (bus.resp_valid) begin
                pulses++;
                chk("held_resp_data", bus.resp_data, 8'h3c);
            end
        end
        bus.req_valid = 1'b0;
        chk("held_accepts", acc_cnt, 2);
        chk("held_second_accept", acc2, 33);
        chk("held_pulses", pulses, 2);
        for (int i = 0; i < 100 && !bus.req_ready; i++) step();
        chk("held_idle", bus.req_ready, 1);

        // reset mid-STROBE
        accept_req(1'b1, 8'h5a);
        for (int i = 0; i < 8; i++) step();
        chk("mid_strobe_en", bus.lcd_en, 1);
        rst = 1'b1;
        step();
        chk("rst_en", bus.lcd_en, 0);
        chk("rst_rw", bus.lcd_rw, 0);
        chk("rst_rs", bus.lcd_rs, 0);
        chk("rst_busy", bus.bus_busy, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_ready", bus.req_ready, 0);
        rst = 1'b0;
        resp_after = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.resp_valid || bus.lcd_en) resp_after++;
        end
        chk("rst_no_activity", resp_after, 0);
        do_read(1'b1, 8'h66, 0, 8'h00, 1, 8'h66, 1'b0);

`ifdef LCD_BF_POLL_EN
        do_read(1'b0, 8'h80, 60, 8'h10, 3, 8'h10, 1'b0);
        do_read(1'b0, 8'h80, 0, 8'h80, 4, 8'h80, 1'b1);
        do_read(1'b1, 8'h80, 0, 8'h00, 1, 8'h80, 1'b0);
`else
        do_read(1'b0, 8'h80, 0, 8'h00, 1, 8'h80, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
